// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-master memory bus arbiter: request ids, FSM states
// and the store size encoding carried on the bus.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_w_size_e;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   typedef logic [0:0] arb_id_t;

   localparam arb_id_t ARB_REQ_FETCH = 1'b0;
   localparam arb_id_t ARB_REQ_DATA  = 1'b1;

endpackage

// File: rtl/arb_owner_fifo.sv
// Records which requester owns each outstanding read so responses can be
// steered back in request order.
module arb_owner_fifo
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    push,
   input  arb_id_t push_id,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output arb_id_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   arb_id_t     mem_q [DEPTH];
   arb_id_t     mem_d [DEPTH];
   logic        do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_id;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge i_clk) mem_q <= mem_d;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory slave port between instruction fetch (0) and the memory
// stage (1); holds a grant until the slave accepts and routes reads back in order.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int OUTSTANDING_DEPTH = 4,
   parameter int FIXED_PRIORITY    = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_m_valid,
   output logic [1:0]       o_m_ready,
   input  logic [1:0]       i_m_w_en,
   input  logic [1:0][31:0] i_m_addr,
   input  logic [1:0][31:0] i_m_w_data,
   input  logic [1:0][1:0]  i_m_w_size,
   output logic [1:0]       o_m_r_valid,
   output logic [31:0]      o_m_r_data,
   output logic             o_s_valid,
   input  logic             i_s_ready,
   output logic             o_s_w_en,
   output logic [31:0]      o_s_addr,
   output logic [31:0]      o_s_w_data,
   output mem_w_size_e      o_s_w_size,
   input  logic             i_s_r_valid,
   input  logic [31:0]      i_s_r_data
);

   arb_state_e state_q, state_d;
   arb_id_t    lock_id_q, lock_id_d;
   arb_id_t    last_grant_q, last_grant_d;
   arb_id_t    winner, sel, fifo_head;
   logic [1:0] eligible;
   logic       accept, can_push, push, pop, fifo_full, fifo_empty;

   assign pop      = i_s_r_valid && !fifo_empty && !i_rst;
   // A pop in the same cycle frees the slot a new read needs.
   assign can_push = !fifo_full || pop;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < 2; i++) eligible[i] = i_m_valid[i] && (i_m_w_en[i] || can_push);

      if (&eligible) winner = (FIXED_PRIORITY != 0) ? ARB_REQ_DATA : ~last_grant_q;
      else           winner = eligible[1] ? ARB_REQ_DATA : ARB_REQ_FETCH;

      state_d      = state_q;
      lock_id_d    = lock_id_q;
      last_grant_d = last_grant_q;
      sel          = winner;
      o_s_valid    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            sel       = winner;
            o_s_valid = !i_rst && (|eligible);
         end
         ARB_LOCKED: begin
            sel       = lock_id_q;
            o_s_valid = !i_rst && eligible[lock_id_q];
         end
         default: state_d = ARB_IDLE;
      endcase

      accept = o_s_valid && i_s_ready;
      if (accept) begin
         last_grant_d = sel;
         state_d      = ARB_IDLE;
      end else if (o_s_valid) begin
         lock_id_d = sel;
         state_d   = ARB_LOCKED;
      end
   end

   assign push        = accept && !i_m_w_en[sel];
   assign o_m_ready   = accept ? (2'b01 << sel) : 2'b00;
   assign o_m_r_valid = pop ? (2'b01 << fifo_head) : 2'b00;
   assign o_m_r_data  = i_s_r_data;
   assign o_s_w_en    = i_m_w_en[sel];
   assign o_s_addr    = i_m_addr[sel];
   assign o_s_w_data  = i_m_w_data[sel];
   assign o_s_w_size  = mem_w_size_e'(i_m_w_size[sel]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ARB_IDLE;
         lock_id_q    <= ARB_REQ_FETCH;
         last_grant_q <= ARB_REQ_DATA;
      end else begin
         state_q      <= state_d;
         lock_id_q    <= lock_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   arb_owner_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_owner_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .push    (push),
      .push_id (sel),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   // A response with nothing outstanding is a slave protocol error; it is dropped.
   assert property (@(posedge i_clk) disable iff (i_rst) !(i_s_r_valid && fifo_empty));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: stimulus queues expected slave handshakes and read responses,
// a negedge monitor pops and compares them as the arbiter presents them.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       m_valid, m_ready, m_w_en, m_r_valid;
   logic [1:0][31:0] m_addr, m_w_data;
   logic [1:0][1:0]  m_w_size;
   logic [31:0]      m_r_data, s_addr, s_w_data, s_r_data;
   logic             s_valid, s_ready, s_w_en, s_r_valid;
   mem_w_size_e      s_w_size;

   logic [1:0]       fp_valid, fp_ready, fp_r_valid;
   logic [31:0]      fp_r_data, fp_addr, fp_w_data;
   logic             fp_s_valid, fp_s_w_en;
   mem_w_size_e      fp_w_size;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.OUTSTANDING_DEPTH(4), .FIXED_PRIORITY(0)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m_valid(m_valid), .o_m_ready(m_ready), .i_m_w_en(m_w_en),
      .i_m_addr(m_addr), .i_m_w_data(m_w_data), .i_m_w_size(m_w_size),
      .o_m_r_valid(m_r_valid), .o_m_r_data(m_r_data),
      .o_s_valid(s_valid), .i_s_ready(s_ready), .o_s_w_en(s_w_en),
      .o_s_addr(s_addr), .o_s_w_data(s_w_data), .o_s_w_size(s_w_size),
      .i_s_r_valid(s_r_valid), .i_s_r_data(s_r_data)
   );

   // Fixed-priority instance sees writes only, so it never expects responses.
   mem_bus_arbiter #(.OUTSTANDING_DEPTH(4), .FIXED_PRIORITY(1)) dut_fp (
      .i_clk(clk), .i_rst(rst),
      .i_m_valid(fp_valid), .o_m_ready(fp_ready), .i_m_w_en(2'b11),
      .i_m_addr(m_addr), .i_m_w_data(m_w_data), .i_m_w_size(m_w_size),
      .o_m_r_valid(fp_r_valid), .o_m_r_data(fp_r_data),
      .o_s_valid(fp_s_valid), .i_s_ready(1'b1), .o_s_w_en(fp_s_w_en),
      .o_s_addr(fp_addr), .o_s_w_data(fp_w_data), .o_s_w_size(fp_w_size),
      .i_s_r_valid(1'b0), .i_s_r_data(32'h0)
   );

   typedef struct { logic [1:0] rdy; logic [31:0] addr; logic w; } acc_t;
   typedef struct { logic [1:0] rv;  logic [31:0] data; } rsp_t;
   acc_t acc_q[$];
   rsp_t rsp_q[$];
   acc_t mon_a;
   rsp_t mon_r;
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      m_valid   = 2'b00;
      m_w_en    = 2'b00;
      s_ready   = 1'b0;
      s_r_valid = 1'b0;
      s_r_data  = 32'h0;
      fp_valid  = 2'b00;
   endtask

   task automatic set_m(input int i, input logic w, input logic [31:0] a);
      m_valid[i]  = 1'b1;
      m_w_en[i]   = w;
      m_addr[i]   = a;
      m_w_data[i] = a ^ 32'h5A5A_0000;
      m_w_size[i] = 2'b10;
   endtask

   task automatic exp_acc(input int id, input logic [31:0] a, input logic w);
      acc_t e;
      e.rdy  = (id == 0) ? 2'b01 : 2'b10;
      e.addr = a;
      e.w    = w;
      acc_q.push_back(e);
   endtask

   task automatic rsp(input int id, input logic [31:0] d);
      rsp_t e;
      s_r_valid = 1'b1;
      s_r_data  = d;
      e.rv      = (id == 0) ? 2'b01 : 2'b10;
      e.data    = d;
      rsp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (s_valid && s_ready) begin
            if (acc_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL acc_unexpected: got addr %0h, expected no handshake", s_addr);
            end else begin
               mon_a = acc_q.pop_front();
               chk("acc_ready", m_ready, mon_a.rdy);
               chk("acc_addr", s_addr, mon_a.addr);
               chk("acc_w_en", s_w_en, mon_a.w);
            end
         end else if (m_ready != 2'b00) begin
            chk("ready_without_accept", m_ready, 2'b00);
         end
         if (m_r_valid != 2'b00) begin
            if (rsp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL rsp_unexpected: got r_valid %0b, expected none", m_r_valid);
            end else begin
               mon_r = rsp_q.pop_front();
               chk("rsp_valid", m_r_valid, mon_r.rv);
               chk("rsp_data", m_r_data, mon_r.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      m_addr = '0; m_w_data = '0; m_w_size = '0;
      idle_in();
      m_valid = 2'b11;
      #3;
      chk("rst_s_valid", s_valid, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_r_valid", m_r_valid, 0);
      step(); step();
      rst = 1'b0;
      idle_in();
      #2 chk("post_rst_s_valid", s_valid, 0);
      step();

      // Single read from the memory stage, answered next cycle.
      idle_in(); set_m(1, 0, 32'h100); s_ready = 1; exp_acc(1, 32'h100, 0); step();
      idle_in(); rsp(1, 32'hDEADBEEF); step();

      // Round-robin with both masters storing every cycle: 0,1,0,1.
      idle_in(); set_m(0, 1, 32'h200); set_m(1, 1, 32'h300); s_ready = 1; exp_acc(0, 32'h200, 1); step();
      idle_in(); set_m(0, 1, 32'h204); set_m(1, 1, 32'h300); s_ready = 1; exp_acc(1, 32'h300, 1); step();
      idle_in(); set_m(0, 1, 32'h204); set_m(1, 1, 32'h304); s_ready = 1; exp_acc(0, 32'h204, 1); step();
      idle_in(); set_m(0, 1, 32'h208); set_m(1, 1, 32'h304); s_ready = 1; exp_acc(1, 32'h304, 1); step();

      // Fixed priority: data wins every tie, fetch only when alone.
      for (int k = 0; k < 3; k++) begin
         idle_in(); fp_valid = 2'b11;
         #2 chk("fp_tie_grant", fp_ready, 2'b10);
         step();
      end
      idle_in(); fp_valid = 2'b01;
      #2 chk("fp_single_grant", fp_ready, 2'b01);
      step();

      // Grant lock: fetch stalls three cycles, data arrives in cycle 1.
      idle_in(); set_m(0, 0, 32'h400);
      #2 chk("lock_s_valid", s_valid, 1);
      chk("lock_addr_c0", s_addr, 32'h400);
      step();
      for (int k = 0; k < 2; k++) begin
         idle_in(); set_m(0, 0, 32'h400); set_m(1, 0, 32'h500);
         #2 chk("lock_addr_held", s_addr, 32'h400);
         chk("lock_no_ready", m_ready, 2'b00);
         step();
      end
      idle_in(); set_m(0, 0, 32'h400); set_m(1, 0, 32'h500); s_ready = 1; exp_acc(0, 32'h400, 0); step();
      idle_in(); set_m(1, 0, 32'h500); s_ready = 1; exp_acc(1, 32'h500, 0); step();
      idle_in(); rsp(0, 32'h1111_1111); step();
      idle_in(); rsp(1, 32'h2222_2222); step();

      // Outstanding limit: four reads fill the owner FIFO.
      for (int k = 0; k < 4; k++) begin
         idle_in(); set_m(0, 0, 32'h600 + 32'(4 * k)); s_ready = 1; exp_acc(0, 32'h600 + 32'(4 * k), 0); step();
      end
      idle_in(); set_m(0, 0, 32'h610); s_ready = 1;
      #2 chk("full_read_blocked", s_valid, 0);
      step();
      idle_in(); set_m(0, 0, 32'h610); set_m(1, 1, 32'h700); s_ready = 1; exp_acc(1, 32'h700, 1); step();
      idle_in(); set_m(0, 0, 32'h610); s_ready = 1; rsp(0, 32'hA0); exp_acc(0, 32'h610, 0); step();
      for (int k = 1; k <= 4; k++) begin
         idle_in(); rsp(0, 32'hA0 + 32'(k)); step();
      end

      // Ordering with a push and pop in the same cycle.
      idle_in(); set_m(0, 0, 32'h800); s_ready = 1; exp_acc(0, 32'h800, 0); step();
      idle_in(); set_m(1, 0, 32'h900); s_ready = 1; exp_acc(1, 32'h900, 0); step();
      idle_in(); set_m(0, 0, 32'h804); s_ready = 1; exp_acc(0, 32'h804, 0); rsp(0, 32'hAAAA_0001); step();
      idle_in(); rsp(1, 32'hBBBB_0002); step();
      idle_in(); rsp(0, 32'hCCCC_0003); step();

      // Reset while locked with two reads outstanding.
      idle_in(); set_m(1, 0, 32'hB00); s_ready = 1; exp_acc(1, 32'hB00, 0); step();
      idle_in(); set_m(0, 0, 32'hB04); s_ready = 1; exp_acc(0, 32'hB04, 0); step();
      idle_in(); set_m(0, 0, 32'hB08); step();
      idle_in(); set_m(0, 0, 32'hB08); rst = 1'b1; step();
      rst = 1'b0;
      idle_in();
      #2 chk("rst2_s_valid", s_valid, 0);
      chk("rst2_m_ready", m_ready, 0);
      chk("rst2_r_valid", m_r_valid, 0);
      chk("rst2_fifo_empty", dut.fifo_empty, 1);
      step();
      idle_in(); set_m(0, 1, 32'hC00); set_m(1, 1, 32'hD00); s_ready = 1; exp_acc(0, 32'hC00, 1); step();
      idle_in(); set_m(1, 1, 32'hD00); s_ready = 1; exp_acc(1, 32'hD00, 1); step();
      idle_in(); step();

      chk("acc_queue_drained", 64'(acc_q.size()), 0);
      chk("rsp_queue_drained", 64'(rsp_q.size()), 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
